// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronised frame capture, E0/F0 prefix decode, decoded-key FIFO.
// Optional inactivity abort of partial frames when PS2_KBD_RX_TIMEOUT_EN is defined.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        ready,
  input  logic                        ovf_clr,
  output logic                        valid,
  output logic [7:0]                  key_data,
  output logic                        key_break,
  output logic                        key_ext,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  // Synchronisers idle high so reset release never looks like a falling edge.
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_sample, w_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sample = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_data   = r_dat_sync[SYNC_STAGES-1];

  logic [3:0]  r_bitcnt;
  logic [10:0] r_frame;
  logic [10:0] w_frame;
  logic [7:0]  w_code;
  logic        w_last, w_accept, w_reject, w_timeout;

  assign w_last   = w_sample && (r_bitcnt == 4'd10);
  assign w_frame  = {w_data, r_frame[9:0]};
  assign w_code   = w_frame[8:1];
  assign w_accept = w_last && !w_frame[0] && w_frame[10] && (^w_frame[9:1]);
  assign w_reject = w_last && !w_accept;

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  assign w_timeout = !w_sample && (r_bitcnt != 4'd0) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        r_tmo <= '0;
    else if (w_sample || r_bitcnt == 4'd0 || w_timeout) r_tmo <= '0;
    else                                               r_tmo <= r_tmo + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt  <= '0;
      r_frame   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= w_reject | w_timeout;
      if (w_sample) begin
        r_frame[r_bitcnt] <= w_data;
        r_bitcnt          <= w_last ? 4'd0 : r_bitcnt + 4'd1;
      end else if (w_timeout) begin
        r_bitcnt <= '0;
      end
    end
  end

  state_t r_state, w_state_nxt;
  logic   w_push_req, w_ext, w_brk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    if (w_accept) begin
      case (w_code)
        8'hE0: if (r_state == S_IDLE) w_state_nxt = S_EXT;
        8'hF0: begin
          if (r_state == S_IDLE)     w_state_nxt = S_BRK;
          else if (r_state == S_EXT) w_state_nxt = S_EXT_BRK;
        end
        default: begin
          w_push_req  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full, w_pop, w_push;
  logic [9:0]    w_head;

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = valid && ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_ext, w_brk, w_code};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      else if (ovf_clr)                   r_ovf <= 1'b0;
    end
  end

  assign valid     = (r_count != '0);
  assign w_head    = valid ? r_mem[r_rd_ptr] : 10'd0;
  assign key_ext   = w_head[9];
  assign key_break = w_head[8];
  assign key_data  = w_head[7:0];
  assign count     = r_count;
  assign overflow  = r_ovf;
endmodule
